// File: rtl/ram_latency_ctrl_if.sv
// Arbiter-to-memory request/response bundle for ram_latency_ctrl.
// The master side is the cache arbiter; the slave side is the memory stage.
interface ram_latency_ctrl_if;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_latency_ctrl.sv
// Word-addressed main memory with a programmable access latency.
// Supports address-change restart and reports illegal requests as ERROR.
module ram_latency_ctrl_param_chk #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 2
);
    if ((LAT < 1) || (LAT > 15)) begin : g_lat_bad
        $error("ram_latency_ctrl: LAT must lie in 1..15");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_bad
        $error("ram_latency_ctrl: DEPTH must be a power of two >= 2");
    end
endmodule

module ram_latency_ctrl #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 2,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input logic               CLK,
    input logic               nRST,
    ram_latency_ctrl_if.slave bus
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [3:0]  RELOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    ramstate_t     state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_q, wr_d;
    logic [31:0]   load_q, load_d;
    logic [31:0]   mem [DEPTH];

    logic          req_s, bad_s, start_s, mem_we_s;
    logic [31:0]   offset_s, word_s;
    logic [AW-1:0] idx_s;

    ram_latency_ctrl_param_chk #(.DEPTH(DEPTH), .LAT(LAT)) u_param_chk ();

    // Decode request legality and word index
    always_comb begin
        offset_s = bus.ramaddr - BASE;
        word_s   = offset_s >> 32'd2;
        idx_s    = word_s[AW-1:0];
        req_s    = bus.ramREN | bus.ramWEN;
        bad_s    = (bus.ramREN & bus.ramWEN)
                 | (bus.ramaddr[1:0] != 2'b00)
                 | (bus.ramaddr < BASE)
                 | (word_s >= 32'(DEPTH));
    end

    // Next-state, counter, latch and read-capture logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_d   = load_q;
        mem_we_s = 1'b0;
        start_s  = 1'b0;
        case (state_q)
            BUSY: begin
                if (!req_s) begin
                    state_d = FREE;
                end else if (bad_s) begin
                    state_d = ERROR;
                end else if ((bus.ramaddr != addr_q) || (bus.ramWEN != wr_q)) begin
                    start_s = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ACCESS;
                    if (!wr_q) begin
                        load_d = mem[idx_q];
                    end else begin
                        load_d = load_q;
                    end
                end
            end
            ACCESS, FREE, ERROR: begin
                // Only the ACCESS exit commits, and only while the write is still held
                mem_we_s = (state_q == ACCESS) & wr_q & bus.ramWEN;
                if (!req_s) begin
                    state_d = FREE;
                end else if (bad_s) begin
                    state_d = ERROR;
                end else begin
                    start_s = 1'b1;
                end
            end
            default: begin
                state_d = FREE;
            end
        endcase
        state_d = start_s ? BUSY        : state_d;
        cnt_d   = start_s ? RELOAD      : cnt_d;
        addr_d  = start_s ? bus.ramaddr : addr_q;
        idx_d   = start_s ? idx_s       : idx_q;
        wr_d    = start_s ? bus.ramWEN  : wr_q;
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= FREE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            idx_q   <= {AW{1'b0}};
            wr_q    <= 1'b0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            load_q  <= load_d;
        end
    end

    // Storage array; contents survive reset, but reset blocks a pending commit
    always_ff @(posedge CLK) begin
        if (nRST && mem_we_s) begin
            mem[idx_q] <= bus.ramstore;
        end
    end

    assign bus.ramload  = load_q;
    assign bus.ramstate = state_q;
endmodule

// File: tb/tb_ram_latency_ctrl.sv
// Self-checking bench for ram_latency_ctrl: directed scenarios plus a
// randomized run, all compared against a transaction-level memory model.
module tb_ram_latency_ctrl;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [1:0]  S_F = 2'd0, S_B = 2'd1, S_A = 2'd2, S_E = 2'd3;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: phase, edges since launch, latched request, memory
    logic [1:0]  m_state   = S_F;
    int          m_elapsed = 0;
    logic [31:0] m_addr    = 32'd0;
    logic        m_wr      = 1'b0;
    logic [31:0] m_load    = 32'd0;
    logic [31:0] m_mem [int];

    ram_latency_ctrl_if bus ();

    ram_latency_ctrl #(.DEPTH(DEPTH), .LAT(LAT), .BASE(BASE)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic is_bad(input logic ren, input logic wen, input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (ren && wen) || (a[1:0] != 2'b00) || (off < 0) || ((off / 4) >= longint'(DEPTH));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(((longint'(a) - longint'(BASE)) / 4) % longint'(DEPTH));
    endfunction

    task automatic model_edge();
        logic ren, wen;
        logic [31:0] a;
        ren = bus.ramREN;
        wen = bus.ramWEN;
        a   = bus.ramaddr;
        if (!nRST) begin
            m_state = S_F; m_elapsed = 0; m_addr = 32'd0; m_wr = 1'b0; m_load = 32'd0;
        end else begin
            if (m_state == S_A && m_wr && wen) m_mem[word_of(m_addr)] = bus.ramstore;
            if (m_state == S_B && (ren || wen) && !is_bad(ren, wen, a) && a == m_addr && wen == m_wr) begin
                m_elapsed++;
                if (m_elapsed == int'(LAT)) begin
                    m_state = S_A;
                    if (!m_wr) m_load = m_mem.exists(word_of(m_addr)) ? m_mem[word_of(m_addr)] : 32'hxxxx_xxxx;
                end
            end else if (!(ren || wen)) begin
                m_state = S_F;
            end else if (is_bad(ren, wen, a)) begin
                m_state = S_E;
            end else begin
                m_state = S_B; m_elapsed = 0; m_addr = a; m_wr = wen;
            end
        end
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] s);
        bus.ramREN = ren; bus.ramWEN = wen; bus.ramaddr = a; bus.ramstore = s;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        repeat (LAT + 2) drive(1'b0, 1'b1, a, d);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) nRST = 1'b1;
            drive(1'b0, 1'b0, 32'd0, 32'd0);
            n_chk++;
            if (bus.ramstate !== S_F || bus.ramload !== 32'd0)
                $display("FAIL reset cyc%0d: state=%0d load=%h, want state=0 load=0", i, bus.ramstate, bus.ramload);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        logic [1:0] exp_s [8] = '{S_B, S_B, S_A, S_B, S_F, S_B, S_B, S_A};
        for (int i = 0; i < 8; i++) begin
            if (i < 4)       drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
            else if (i == 4) drive(1'b0, 1'b0, 32'd0, 32'd0);
            else             drive(1'b1, 1'b0, 32'h10, 32'd0);
            n_chk++;
            if (bus.ramstate !== exp_s[i])
                $display("FAIL wr_rd state cyc%0d: got %0d want %0d", i, bus.ramstate, exp_s[i]);
            else n_pass++;
        end
        n_chk++;
        if (bus.ramload !== 32'hDEAD_BEEF) $display("FAIL wr_rd load: got %h want deadbeef", bus.ramload);
        else n_pass++;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_restart();
        logic [1:0] exp_s [4] = '{S_B, S_B, S_B, S_A};
        do_write(32'h20, 32'h1111_2020);
        do_write(32'h24, 32'h0000_0055);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, (i == 0) ? 32'h20 : 32'h24, 32'd0);
            n_chk++;
            if (bus.ramstate !== exp_s[i])
                $display("FAIL restart state cyc%0d: got %0d want %0d", i, bus.ramstate, exp_s[i]);
            else n_pass++;
        end
        n_chk++;
        if (bus.ramload !== 32'h55) $display("FAIL restart load: got %h want 00000055", bus.ramload);
        else n_pass++;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_s [6] = '{S_B, S_B, S_A, S_B, S_B, S_A};
        logic [31:0] exp_d [2] = '{32'hA0A0_0000, 32'hB0B0_0004};
        do_write(32'h0, exp_d[0]);
        do_write(32'h4, exp_d[1]);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, (i < 3) ? 32'h0 : 32'h4, 32'd0);
            n_chk++;
            if (bus.ramstate !== exp_s[i])
                $display("FAIL b2b state cyc%0d: got %0d want %0d", i, bus.ramstate, exp_s[i]);
            else n_pass++;
            if (i == 2 || i == 5) begin
                n_chk++;
                if (bus.ramload !== exp_d[i / 3])
                    $display("FAIL b2b load cyc%0d: got %h want %h", i, bus.ramload, exp_d[i / 3]);
                else n_pass++;
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_errors();
        logic        r_t [16] = '{1,1,1,0, 1,1,1,0, 1,1,0,0, 1,1,1,0};
        logic        w_t [16] = '{1,1,1,0, 0,0,0,0, 0,0,1,0, 0,0,0,0};
        logic [31:0] a_t [16] = '{32'h10, 32'h10, 32'h10, 32'h0, 32'h10, 32'h10, 32'h10, 32'h0,
                                  32'h2, 32'(DEPTH * 4), 32'(DEPTH * 4), 32'h0,
                                  32'h10, 32'h11, 32'h10, 32'h0};
        logic [1:0]  e_t [16] = '{S_E, S_E, S_E, S_F, S_B, S_B, S_A, S_F,
                                  S_E, S_E, S_E, S_F, S_B, S_E, S_B, S_F};
        for (int i = 0; i < 16; i++) begin
            drive(r_t[i], w_t[i], a_t[i], 32'hBAD0_BAD0);
            n_chk++;
            if (bus.ramstate !== e_t[i])
                $display("FAIL errors state cyc%0d: got %0d want %0d", i, bus.ramstate, e_t[i]);
            else n_pass++;
            if (i == 6) begin
                n_chk++;
                if (bus.ramload !== 32'hDEAD_BEEF)
                    $display("FAIL errors mem_kept: got %h want deadbeef", bus.ramload);
                else n_pass++;
            end
        end
    endtask

    task automatic test_abort();
        do_write(32'h40, 32'hC0FF_EE00);
        drive(1'b0, 1'b1, 32'h40, 32'h0000_1234);
        n_chk++;
        if (bus.ramstate !== S_B) $display("FAIL abort busy: got %0d want 1", bus.ramstate);
        else n_pass++;
        nRST = 1'b0;
        drive(1'b0, 1'b1, 32'h40, 32'h0000_1234);
        n_chk++;
        if (bus.ramstate !== S_F || bus.ramload !== 32'd0)
            $display("FAIL abort reset: state=%0d load=%h want 0/0", bus.ramstate, bus.ramload);
        else n_pass++;
        nRST = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (LAT + 1) drive(1'b1, 1'b0, 32'h40, 32'd0);
        n_chk++;
        if (bus.ramstate !== S_A || bus.ramload !== 32'hC0FF_EE00)
            $display("FAIL abort no_commit: state=%0d load=%h want 2/c0ffee00", bus.ramstate, bus.ramload);
        else n_pass++;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_random();
        logic r = 1'b0, w = 1'b0;
        logic [31:0] a = 32'd0, s = 32'd0;
        int hold = 0;
        for (int k = 0; k < 16; k++) do_write(32'(k * 4), $urandom);
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, LAT + 3);
                a = 32'($urandom_range(0, 15) * 4);
                s = $urandom;
                case ($urandom_range(0, 3))
                    0: begin r = 1'b0; w = 1'b0; end
                    1: begin r = 1'b1; w = 1'b0; end
                    2: begin r = 1'b0; w = 1'b1; end
                    default: begin
                        r = 1'b1; w = 1'($urandom_range(0, 1));
                        if (!w) a = ($urandom_range(0, 1) == 0) ? (a | 32'd1) : 32'(DEPTH * 4 + 8);
                    end
                endcase
            end
            hold--;
            drive(r, w, a, s);
            n_chk++;
            if (bus.ramstate !== m_state || bus.ramload !== m_load)
                $display("FAIL random cyc%0d: state=%0d load=%h want %0d/%h", i, bus.ramstate, bus.ramload, m_state, m_load);
            else n_pass++;
        end
    endtask

    initial begin
        bus.ramREN = 1'b0; bus.ramWEN = 1'b0; bus.ramaddr = 32'd0; bus.ramstore = 32'd0;
        test_reset();
        test_write_read();
        test_restart();
        test_back_to_back();
        test_errors();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
